mem_instr_cargable: RTL and testbench

Parametrised, runtime-loadable instruction memory for the MIPS fetch stage. A byte-serial loader FSM receives a program from the debug/UART unit, packs bytes into big-endian words and writes them sequentially from word 0. Once loaded, the block serves synchronous fetches addressed by the byte PC, with stall support and out-of-range detection.

---
 rtl/mem_instr_cargable_pkg.sv | 12 +
 rtl/mem_instr_cargable_if.sv | 32 +++
 rtl/mem_instr_byte_packer.sv | 46 ++++
 rtl/mem_instr_cargable.sv | 121 ++++++++++++
 tb/tb_mem_instr_cargable.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/mem_instr_cargable_pkg.sv
// Shared constants for the loadable instruction memory.
// State encodings, NOP value and the default end-of-program marker.
package mem_instr_cargable_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [31:0] NOP_WORD      = 32'h0000_0000;
    localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;

endpackage

// File: rtl/mem_instr_cargable_if.sv
// Fetch and byte-loader signal bundle of the instruction memory.
// slave = memory side, master = fetch/loader driver side.
interface mem_instr_cargable_if #(
    parameter int NBITS     = 32,
    parameter int CELDAS    = 64,
    parameter int BYTE_BITS = 8
);
    localparam int CW = $clog2(CELDAS + 1);

    logic [NBITS-1:0]     i_PC;
    logic                 i_fetch_en;
    logic [NBITS-1:0]     o_Instruction;
    logic                 o_pc_err;
    logic                 i_load_start;
    logic                 i_load_valid;
    logic [BYTE_BITS-1:0] i_load_byte;
    logic                 o_load_ready;
    logic                 o_load_done;
    logic [CW-1:0]        o_load_count;

    modport slave (
        input  i_PC, i_fetch_en, i_load_start, i_load_valid, i_load_byte,
        output o_Instruction, o_pc_err, o_load_ready, o_load_done,
        output o_load_count
    );

    modport master (
        output i_PC, i_fetch_en, i_load_start, i_load_valid, i_load_byte,
        input  o_Instruction, o_pc_err, o_load_ready, o_load_done,
        input  o_load_count
    );
endinterface

// File: rtl/mem_instr_byte_packer.sv
// Packs loader bytes into big-endian words; first byte lands in the MSBs.
// o_word_valid strobes in the cycle the last byte of a word is accepted.
module mem_instr_byte_packer #(
    parameter int NBITS     = 32,
    parameter int BYTE_BITS = 8
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_clr,
    input  logic                 i_byte_en,
    input  logic [BYTE_BITS-1:0] i_byte,
    output logic [NBITS-1:0]     o_word,
    output logic                 o_word_valid
);
    localparam int NB = NBITS / BYTE_BITS;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;
    localparam int SW = NBITS - BYTE_BITS;

    logic [SW-1:0] shift_q, shift_d;
    logic [CW-1:0] cnt_q, cnt_d;

    assign o_word       = {shift_q, i_byte};
    assign o_word_valid = i_byte_en && (cnt_q == CW'(NB - 1));

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (i_clr) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (i_byte_en) begin
            shift_d = o_word[SW-1:0];
            cnt_d   = o_word_valid ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: rtl/mem_instr_cargable.sv
// Runtime-loadable instruction memory with byte-serial loader and fetch port.
// Define MEM_INSTR_HALT_STOP_EN to end a load early on a stored HALT_WORD.
import mem_instr_cargable_pkg::*;

module mem_instr_cargable #(
    parameter int               NBITS     = 32,
    parameter int               CELDAS    = 64,
    parameter int               BYTE_BITS = 8,
    parameter logic [NBITS-1:0] HALT_WORD = NBITS'(HALT_WORD_DEF)
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    mem_instr_cargable_if.slave  bus
);
    localparam int CW = $clog2(CELDAS + 1);
    localparam int AW = (CELDAS > 1) ? $clog2(CELDAS) : 1;
    localparam int IW = NBITS - 2;
`ifdef MEM_INSTR_HALT_STOP_EN
    localparam logic HALT_EN = 1'b1;
`else
    localparam logic HALT_EN = 1'b0;
`endif

    logic [NBITS-1:0] mem [CELDAS];

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [NBITS-1:0] instr_q, instr_d;
    logic             err_q, err_d;

    logic             byte_en, pk_clr, word_valid, we;
    logic [NBITS-1:0] word;
    logic [IW-1:0]    idx;
    logic             unused_pc;

    assign idx       = bus.i_PC[NBITS-1:2];
    assign unused_pc = ^bus.i_PC[1:0];
    assign byte_en   = bus.i_load_valid && (state_q == S_LOAD);
    assign pk_clr    = (state_q == S_IDLE) && bus.i_load_start;
    assign we        = word_valid;

    mem_instr_byte_packer #(
        .NBITS     (NBITS),
        .BYTE_BITS (BYTE_BITS)
    ) u_packer (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_clr        (pk_clr),
        .i_byte_en    (byte_en),
        .i_byte       (bus.i_load_byte),
        .o_word       (word),
        .o_word_valid (word_valid)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        unique case (1'b1)
            state_q == S_LOAD: begin
                if (word_valid) begin
                    count_d = count_q + CW'(1);
                    if (count_d == CW'(CELDAS) ||
                        (HALT_EN && word == HALT_WORD))
                        state_d = S_DONE;
                end
            end
            state_q == S_DONE: state_d = S_IDLE;
            default: begin
                if (bus.i_load_start) begin
                    state_d = S_LOAD;
                    count_d = '0;
                end
            end
        endcase
    end

    // Fetches are served only while idle; loading yields NOPs.
    always_comb begin
        instr_d = instr_q;
        err_d   = err_q;
        if (bus.i_fetch_en) begin
            if (state_q != S_IDLE) begin
                instr_d = NBITS'(NOP_WORD);
                err_d   = 1'b0;
            end else if (!bus.i_load_start) begin
                if (idx >= IW'(CELDAS)) begin
                    instr_d = NBITS'(NOP_WORD);
                    err_d   = 1'b1;
                end else begin
                    instr_d = mem[idx[AW-1:0]];
                    err_d   = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= S_IDLE;
            count_q <= '0;
            instr_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            instr_q <= instr_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (we)
            mem[count_q[AW-1:0]] <= word;
    end

    assign bus.o_Instruction = instr_q;
    assign bus.o_pc_err      = err_q;
    assign bus.o_load_ready  = (state_q == S_LOAD);
    assign bus.o_load_done   = (state_q == S_DONE);
    assign bus.o_load_count  = count_q;
endmodule

// File: tb/tb_mem_instr_cargable.sv
// Directed bench for mem_instr_cargable with CELDAS=4.
// Covers reset, loading, fetch, range errors, stall, mid-load reset.
module tb_mem_instr_cargable;
    localparam int NBITS  = 32;
    localparam int CELDAS = 4;
    localparam int BB     = 8;

    logic i_clk = 1'b0;
    logic i_reset_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;
    int   done_cnt = 0;

    always #5 i_clk = ~i_clk;

    mem_instr_cargable_if #(
        .NBITS(NBITS), .CELDAS(CELDAS), .BYTE_BITS(BB)
    ) bus ();

    mem_instr_cargable #(
        .NBITS(NBITS), .CELDAS(CELDAS), .BYTE_BITS(BB)
    ) dut (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .bus       (bus.slave)
    );

    always @(negedge i_clk)
        if (bus.o_load_done === 1'b1) done_cnt++;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.i_load_valid = 1'b1;
        bus.i_load_byte  = b;
        tick();
        bus.i_load_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
    endtask

    task automatic start_load();
        bus.i_load_start = 1'b1;
        tick();
        bus.i_load_start = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] pc);
        bus.i_PC       = pc;
        bus.i_fetch_en = 1'b1;
        tick();
        bus.i_fetch_en = 1'b0;
    endtask

    initial begin
        bus.i_PC         = '0;
        bus.i_fetch_en   = 1'b0;
        bus.i_load_start = 1'b0;
        bus.i_load_valid = 1'b0;
        bus.i_load_byte  = '0;
        #12;
        check("rst_instr", bus.o_Instruction, 32'h0);
        check("rst_err", 32'(bus.o_pc_err), 32'h0);
        check("rst_cnt", 32'(bus.o_load_count), 32'h0);
        check("rst_ready", 32'(bus.o_load_ready), 32'h0);
        check("rst_done", 32'(bus.o_load_done), 32'h0);
        i_reset_n = 1'b1;
        tick();
        check("idle_hold", bus.o_Instruction, 32'h0);

        // Full load of four words
        start_load();
        check("ld1_ready", 32'(bus.o_load_ready), 32'h1);
        check("ld1_cnt0", 32'(bus.o_load_count), 32'h0);
        send_word(32'h8C62_0002);
        check("ld1_cnt1", 32'(bus.o_load_count), 32'h1);
        send_word(32'h2001_0005);
        check("ld1_cnt2", 32'(bus.o_load_count), 32'h2);
        fetch(32'h0);
        check("ld_fetch_nop", bus.o_Instruction, 32'h0);
        check("ld_fetch_err", 32'(bus.o_pc_err), 32'h0);
        send_word(32'h0);
        for (int i = 0; i < 3; i++) send_byte(8'h00);
        check("ld1_done15", 32'(bus.o_load_done), 32'h0);
        check("ld1_cnt3", 32'(bus.o_load_count), 32'h3);
        send_byte(8'h00);
        check("ld1_done16", 32'(bus.o_load_done), 32'h1);
        check("ld1_cnt4", 32'(bus.o_load_count), 32'h4);
        check("ld1_rdy_off", 32'(bus.o_load_ready), 32'h0);
        tick();
        check("ld1_done_end", 32'(bus.o_load_done), 32'h0);
        check("ld1_pulses", 32'(done_cnt), 32'h1);
        fetch(32'h4);
        check("fetch_w1", bus.o_Instruction, 32'h2001_0005);
        fetch(32'h0);
        check("fetch_w0", bus.o_Instruction, 32'h8C62_0002);

        // Halt-word load
        start_load();
        check("ld2_cnt0", 32'(bus.o_load_count), 32'h0);
        send_word(32'h0000_0024);
        send_word(32'hFFFF_FFFF);
        check("ld2_cnt2", 32'(bus.o_load_count), 32'h2);
`ifdef MEM_INSTR_HALT_STOP_EN
        check("ld2_done", 32'(bus.o_load_done), 32'h1);
        check("ld2_ready", 32'(bus.o_load_ready), 32'h0);
        tick();
`else
        check("ld2_done", 32'(bus.o_load_done), 32'h0);
        check("ld2_ready", 32'(bus.o_load_ready), 32'h1);
        send_word(32'h0);
        send_word(32'h0);
        check("ld2_cnt4", 32'(bus.o_load_count), 32'h4);
        tick();
`endif
        check("ld2_pulses", 32'(done_cnt), 32'h2);

        // Out-of-range and stall
        fetch(32'(4 * CELDAS));
        check("oor_instr", bus.o_Instruction, 32'h0);
        check("oor_err", 32'(bus.o_pc_err), 32'h1);
        bus.i_PC = 32'h0;
        tick();
        check("stall_instr", bus.o_Instruction, 32'h0);
        check("stall_err", 32'(bus.o_pc_err), 32'h1);
        fetch(32'h0);
        check("w0_halt", bus.o_Instruction, 32'h0000_0024);
        check("w0_err", 32'(bus.o_pc_err), 32'h0);
        fetch(32'h7);
        check("w1_lowbits", bus.o_Instruction, 32'hFFFF_FFFF);

        // Start ignored during load, then reset mid-load
        start_load();
        send_word(32'hAABB_CCDD);
        send_byte(8'h11);
        start_load();
        check("ign_cnt", 32'(bus.o_load_count), 32'h1);
        check("ign_ready", 32'(bus.o_load_ready), 32'h1);
        send_byte(8'h22);
        i_reset_n = 1'b0;
        #1;
        check("mid_rst_cnt", 32'(bus.o_load_count), 32'h0);
        check("mid_rst_rdy", 32'(bus.o_load_ready), 32'h0);
        #3;
        i_reset_n = 1'b1;
        fetch(32'h0);
        check("keep_w0", bus.o_Instruction, 32'hAABB_CCDD);
        fetch(32'h4);
        check("keep_w1", bus.o_Instruction, 32'hFFFF_FFFF);
        check("rst_pulses", 32'(done_cnt), 32'h2);

        // Bytes offered while idle are dropped
        send_word(32'h5555_5555);
        check("idle_cnt", 32'(bus.o_load_count), 32'h0);
        fetch(32'h0);
        check("idle_nowr", bus.o_Instruction, 32'hAABB_CCDD);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
